jt51_opacc: RTL
===============

JT51_OPACC -- requirements
Module: jt51_opacc

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cen, input, 1, clock enable; no state other than sample/ch_valid clearing changes when low.
REQ-004 SHALL have port zero, input, 1, marks op_in as slot 0 of the 32-slot round.
REQ-005 SHALL have port op_in, input, 14, signed operator output, one slot per cen.
REQ-006 SHALL have port con, input, 3, algorithm of the channel owning the current slot.
REQ-007 SHALL have port rl, input, 2, pan of current channel: bit0 left enable, bit1 right enable.
REQ-008 SHALL have port ovf_clr, input, 1, clears ovf on a cen cycle.
REQ-009 SHALL have port left, output, 16, signed saturated left sample.
REQ-010 SHALL have port right, output, 16, signed saturated right sample.
REQ-011 SHALL have port sample, output, 1, new left/right valid pulse.
REQ-012 SHALL have port ovf, output, 1, sticky saturation flag.
REQ-013 SHALL have port ch_out, output, 16, signed per-channel carrier sum of the previous round.
REQ-014 SHALL have port ch_idx, output, 3, channel of ch_out.
REQ-015 SHALL have port ch_valid, output, 1, ch_out/ch_idx valid pulse.

Function
REQ-016 SHALL keep a 5-bit slot counter: set to 1 on cen with zero=1, else incremented mod 32 on cen; current slot = 0 when zero=1, else counter value.
REQ-017 SHALL decode slot[4:3] as group (0=M1, 1=M2, 2=C1, 3=C2) and slot[2:0] as channel.
REQ-018 SHALL treat a slot as carrier per con: 0-3 C2 only; 4 C1,C2; 5-6 M2,C1,C2; 7 all groups.
REQ-019 SHALL sign-extend op_in to 19 bits and add it to the left accumulator when carrier and rl[0], and to the right accumulator when carrier and rl[1].
REQ-020 SHALL, on slot 0, load each accumulator with that slot's contribution or 0, discarding prior content.
REQ-021 SHALL, on the cen edge consuming slot 31, register left/right as the final 19-bit sums saturated to [-32768, 32767], and pulse sample high for exactly one clk cycle.
REQ-022 SHALL set ovf on any saturation event; ovf_clr clears it; simultaneous set and clear SHALL leave ovf set.
REQ-023 SHALL hold left/right stable between sample pulses.
REQ-024 SHALL keep an 8-entry 16-bit per-channel sum (carriers regardless of rl, wrap on overflow), cleared per channel at its M1 slot.
REQ-025 SHALL, during slots 0-7 of a round, present entry n of the previous round's per-channel sums on ch_out with ch_idx=n, ch_valid high for one clk cycle per cen.
REQ-026 SHALL stay unsynchronised after reset until the first zero; sample and ch_valid SHALL remain low while unsynchronised.
REQ-027 SHALL, when zero arrives while the counter is not 0 (resync), restart at slot 0, abandon the partial round without a sample pulse, and suppress ch_valid for the next 8 slots.
REQ-028 SHALL ignore zero, op_in, con, rl and ovf_clr on cycles with cen low.

Reset
REQ-029 SHALL, while rst_n is low, force counter=0, accumulators=0, per-channel sums=0, left=0, right=0, sample=0, ovf=0, ch_out=0, ch_idx=0, ch_valid=0, unsynchronised.
REQ-030 SHALL resume operation on the first cen after rst_n rises, without requiring a clock while rst_n is low.

Verification
REQ-031 SHALL cover: con=7, rl=3, op_in=+100 for all 32 slots after zero -> sample pulse after slot 31, left=right=3200, ovf=0.
REQ-032 SHALL cover: con=0, rl=1, op_in=+8191 all slots -> only 8 C2 slots summed, left=32767 (saturated from 65528), right=0, ovf=1.
REQ-033 SHALL cover: con=7, rl=3, op_in=-8192 all slots -> left=right=-32768, ovf=1; ovf_clr pulse then clean round -> ovf=0.
REQ-034 SHALL cover: zero re-asserted at slot 12 -> no sample for aborted round, next sample 32 cen later, ch_valid absent for 8 slots.
REQ-035 SHALL cover: con=4, channel 3 op_in=+50 on C1 and C2 only, rl=2 -> right=100, left=0, next round ch_idx=3 shows ch_out=100.
REQ-036 SHALL cover: rst_n low mid-round with cen toggling -> all outputs 0 immediately, no sample before next zero.

Source files
------------

// File: rtl/jt51_opacc.sv
// ============================================================================
//  Module   : jt51_opacc
//  Brief    : Operator output accumulator for a 32-slot FM round. Sums carrier
//             operators into saturated left/right samples and keeps per-channel
//             carrier sums that are replayed during the next round.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt51_opacc (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               zero,
    input  logic signed [13:0] op_in,
    input  logic        [2:0]  con,
    input  logic        [1:0]  rl,
    input  logic               ovf_clr,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               sample,
    output logic               ovf,
    output logic signed [15:0] ch_out,
    output logic        [2:0]  ch_idx,
    output logic               ch_valid
);

    localparam logic [4:0] C_LAST_SLOT = 5'd31;

    logic [4:0]  r_cnt;
    logic        r_synced;
    logic        r_supp;
    logic [18:0] r_acc_l;
    logic [18:0] r_acc_r;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic        r_sample;
    logic        r_ovf;
    logic [15:0] r_ch_out;
    logic [2:0]  r_ch_idx;
    logic        r_ch_valid;
    logic [15:0] r_ch_sum [0:7];

    logic [4:0]  w_slot;
    logic [1:0]  w_grp;
    logic [2:0]  w_ch;
    logic        w_carrier;
    logic [18:0] w_op19;
    logic [15:0] w_op16;
    logic [18:0] w_sum_l;
    logic [18:0] w_sum_r;
    logic        w_last;
    logic        w_supp;
    logic        w_sat_l;
    logic        w_sat_r;

    // Clamp a 19-bit two's complement sum to the 16-bit range
    function automatic logic [15:0] sat16(input logic [18:0] v);
        if (v[18:15] == 4'b0000 || v[18:15] == 4'b1111)
            sat16 = v[15:0];
        else if (v[18])
            sat16 = 16'h8000;
        else
            sat16 = 16'h7fff;
    endfunction

    assign w_slot  = zero ? 5'd0 : r_cnt;
    assign w_grp   = w_slot[4:3];
    assign w_ch    = w_slot[2:0];
    assign w_op19  = {{5{op_in[13]}}, op_in};
    assign w_op16  = {{2{op_in[13]}}, op_in};

    // Carrier decode: which operator groups reach the output for each algorithm
    always_comb begin
        w_carrier = 1'b0;
        case (con)
            3'd4:       w_carrier = w_grp[1];
            3'd5, 3'd6: w_carrier = (w_grp != 2'd0);
            3'd7:       w_carrier = 1'b1;
            default:    w_carrier = (w_grp == 2'd3);
        endcase
    end

    // Slot 0 discards the previous round's totals instead of adding to them
    assign w_sum_l = ((w_slot == 5'd0) ? 19'd0 : r_acc_l) + ((w_carrier && rl[0]) ? w_op19 : 19'd0);
    assign w_sum_r = ((w_slot == 5'd0) ? 19'd0 : r_acc_r) + ((w_carrier && rl[1]) ? w_op19 : 19'd0);
    assign w_sat_l = !(w_sum_l[18:15] == 4'b0000 || w_sum_l[18:15] == 4'b1111);
    assign w_sat_r = !(w_sum_r[18:15] == 4'b0000 || w_sum_r[18:15] == 4'b1111);

    // Only a round that started from a seen zero may produce a sample
    assign w_last  = r_synced && !zero && (r_cnt == C_LAST_SLOT);

    // Channel replay is muted for a round begun without a complete predecessor
    // (first zero after reset, or a zero arriving mid-round)
    always_comb begin
        w_supp = r_supp;
        if (zero)
            w_supp = !r_synced || (r_cnt != 5'd0);
        else if (r_cnt == 5'd0)
            w_supp = 1'b0;
    end

    // Slot counter and synchronisation state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_synced <= 1'b0;
            r_supp   <= 1'b0;
        end else if (cen) begin
            r_cnt  <= zero ? 5'd1 : r_cnt + 5'd1;
            r_supp <= w_supp;
            if (zero)
                r_synced <= 1'b1;
        end
    end

    // Stereo accumulators, saturated sample registers and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_l  <= 19'd0;
            r_acc_r  <= 19'd0;
            r_left   <= 16'd0;
            r_right  <= 16'd0;
            r_sample <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            if (cen) begin
                r_acc_l <= w_sum_l;
                r_acc_r <= w_sum_r;
                if (w_last) begin
                    r_left   <= sat16(w_sum_l);
                    r_right  <= sat16(w_sum_r);
                    r_sample <= 1'b1;
                end
                // A saturation in the same cycle as a clear wins
                if (w_last && (w_sat_l || w_sat_r))
                    r_ovf <= 1'b1;
                else if (ovf_clr)
                    r_ovf <= 1'b0;
            end
        end
    end

    // Per-channel carrier sums; entry n is replayed at slot n before being reused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                r_ch_sum[i] <= 16'd0;
            r_ch_out   <= 16'd0;
            r_ch_idx   <= 3'd0;
            r_ch_valid <= 1'b0;
        end else begin
            r_ch_valid <= 1'b0;
            if (cen) begin
                if (w_grp == 2'd0)
                    r_ch_sum[w_ch] <= w_carrier ? w_op16 : 16'd0;
                else if (w_carrier)
                    r_ch_sum[w_ch] <= r_ch_sum[w_ch] + w_op16;
                if ((r_synced || zero) && !w_supp && (w_grp == 2'd0)) begin
                    r_ch_out   <= r_ch_sum[w_ch];
                    r_ch_idx   <= w_ch;
                    r_ch_valid <= 1'b1;
                end
            end
        end
    end

    assign left     = r_left;
    assign right    = r_right;
    assign sample   = r_sample;
    assign ovf      = r_ovf;
    assign ch_out   = r_ch_out;
    assign ch_idx   = r_ch_idx;
    assign ch_valid = r_ch_valid;

endmodule

`default_nettype wire
